// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word accesses to a word-wide data memory, sub-word stores by read-merge-write.
// Optional build macro LSU_ALIGN_CHECK_EN enables misalignment faults; otherwise addresses are force-aligned.
module load_store_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_write,
   input  logic [XLEN-1:0] req_addr,
   input  logic [XLEN-1:0] req_wdata,
   input  logic [1:0]      req_size,
   input  logic            req_unsigned,
   output logic            resp_valid,
   output logic [XLEN-1:0] resp_rdata,
   output logic            resp_misaligned,
   output logic [XLEN-1:0] mem_idx,
   output logic [XLEN-1:0] mem_write_data,
   output logic            mem_write_enable,
   input  logic [XLEN-1:0] mem_read_data,
   output logic [1:0]      dbg_state_o
);

   // Handshake: a request transfers on a posedge where req_valid && req_ready; req_ready is high only in IDLE.
   typedef enum logic [1:0] {IDLE, ACCESS, MERGE_WR, RESP} state_e;

   state_e            state_q, state_d;
   logic [XLEN-1:0]   addr_q, wdata_q, merge_q, rdata_q;
   logic [1:0]        size_q;
   logic              write_q, unsigned_q, misaligned_q;
   logic [XLEN-1:0]   addr_n;
   logic [1:0]        size_n;
   logic              misalign_n;
   logic [7:0]        ld_byte;
   logic [15:0]       ld_half;
   logic [XLEN-1:0]   ld_ext, st_merged;
   logic              accept;

   assign accept = req_valid && (state_q == IDLE);

   always_comb begin
      addr_n     = req_addr;
      size_n     = req_size;
      misalign_n = 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
      unique case (req_size)
         2'b01:   misalign_n = req_addr[0];
         2'b10:   misalign_n = |req_addr[1:0];
         2'b11:   misalign_n = 1'b1;
         default: misalign_n = 1'b0;
      endcase
`else
      if (req_size == 2'b11) size_n = 2'b10;
      unique case (size_n)
         2'b01:   addr_n[0]   = 1'b0;
         2'b10:   addr_n[1:0] = 2'b00;
         default: addr_n      = req_addr;
      endcase
`endif
   end

   // Lane extraction for loads and lane insertion for sub-word stores.
   always_comb begin
      ld_byte   = mem_read_data[{addr_q[1:0], 3'b000} +: 8];
      ld_half   = mem_read_data[{addr_q[1], 4'b0000} +: 16];
      st_merged = mem_read_data;
      unique case (size_q)
         2'b00: begin
            ld_ext = unsigned_q ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            st_merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
         end
         2'b01: begin
            ld_ext = unsigned_q ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
            st_merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
         end
         default: ld_ext = mem_read_data;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:     if (req_valid) state_d = misalign_n ? RESP : ACCESS;
         ACCESS:   state_d = (write_q && size_q != 2'b10) ? MERGE_WR : RESP;
         MERGE_WR: state_d = RESP;
         RESP:     state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q       <= '0;
         wdata_q      <= '0;
         size_q       <= 2'b00;
         write_q      <= 1'b0;
         unsigned_q   <= 1'b0;
         merge_q      <= '0;
         rdata_q      <= '0;
         misaligned_q <= 1'b0;
      end else begin
         if (accept) begin
            addr_q     <= addr_n;
            wdata_q    <= req_wdata;
            size_q     <= size_n;
            write_q    <= req_write;
            unsigned_q <= req_unsigned;
         end
         if (state_q == ACCESS) merge_q <= st_merged;
         // Response fields change only on entry to RESP so they hold between responses.
         if (state_d == RESP && state_q != RESP) begin
            rdata_q      <= (state_q == ACCESS && !write_q) ? ld_ext : '0;
            misaligned_q <= (state_q == IDLE);
         end
      end
   end

   always_comb begin
      req_ready        = (state_q == IDLE);
      resp_valid       = (state_q == RESP);
      mem_write_enable = 1'b0;
      mem_write_data   = '0;
      if (state_q == ACCESS && write_q && size_q == 2'b10) begin
         mem_write_enable = 1'b1;
         mem_write_data   = wdata_q;
      end else if (state_q == MERGE_WR) begin
         mem_write_enable = 1'b1;
         mem_write_data   = merge_q;
      end
   end

   assign mem_idx         = {addr_q[XLEN-1:2], 2'b00};
   assign resp_rdata      = rdata_q;
   assign resp_misaligned = misaligned_q;
   assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases, random traffic against a memory model, reset abort.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0, req_write = 1'b0, req_unsigned = 1'b0;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic [1:0]  req_size = '0;
   logic        req_ready, resp_valid, resp_misaligned, mem_write_enable;
   logic [31:0] resp_rdata, mem_idx, mem_write_data, mem_read_data;
   logic [1:0]  dbg_state;

   always #5 clk = ~clk;

   load_store_unit dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_size(req_size), .req_unsigned(req_unsigned), .resp_valid(resp_valid),
      .resp_rdata(resp_rdata), .resp_misaligned(resp_misaligned), .mem_idx(mem_idx),
      .mem_write_data(mem_write_data), .mem_write_enable(mem_write_enable),
      .mem_read_data(mem_read_data), .dbg_state_o(dbg_state)
   );

   // Data memory seen by the DUT; the bench preloads it through tb_wr while reset is held.
   logic [31:0] mem [16];
   logic        tb_wr = 1'b0;
   logic [3:0]  tb_idx = '0;
   logic [31:0] tb_data = '0;
   always @(posedge clk) begin
      if (tb_wr) mem[tb_idx] <= tb_data;
      else if (mem_write_enable) mem[mem_idx[5:2]] <= mem_write_data;
   end
   assign mem_read_data = mem[mem_idx[5:2]];

   logic [31:0] exp_mem [16];
   logic [31:0] exp_q[$];
   int          total = 0, bad = 0;
   logic [31:0] last_rdata = '0;
   logic        last_mis = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_load(input logic [31:0] word, input int off, input int nb, input bit uns);
      longint m = (longint'(1) << (8 * nb)) - 1;
      longint v = (longint'(word) >> (8 * off)) & m;
      if (!uns && nb < 4 && v > (m >> 1)) v = v - (m + 1);
      return v[31:0];
   endfunction

   function automatic logic [31:0] model_store(input logic [31:0] word, input int off, input int nb, input logic [31:0] data);
      longint m = ((longint'(1) << (8 * nb)) - 1) << (8 * off);
      longint r = (longint'(word) & ~m) | ((longint'(data) << (8 * off)) & m);
      return r[31:0];
   endfunction

   task automatic init_mem(input int i, input logic [31:0] v);
      @(negedge clk);
      tb_wr = 1'b1; tb_idx = i[3:0]; tb_data = v;
      exp_mem[i] = v;
   endtask

   // One request; optionally keeps req_valid high with junk while busy (must be ignored).
   task automatic do_req(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input bit uns, input bit hold_valid);
      int nb, off, lat, we_cnt_exp, we_cyc_exp, resp_cyc, we_cnt, we_cyc;
      logic [31:0] ea, got_rdata, exp_r;
      logic [3:0]  idx;
      logic [1:0]  sz;
      bit mis, got_mis;
      sz = size;
`ifdef LSU_ALIGN_CHECK_EN
      nb  = 1 << size;
      mis = (size == 2'd3) || ((addr % nb) != 0);
      ea  = addr;
`else
      if (size == 2'd3) sz = 2'd2;
      nb  = 1 << sz;
      mis = 1'b0;
      ea  = addr - (addr % nb);
`endif
      off = ea % 4;
      idx = ea[5:2];
      we_cnt_exp = 0; we_cyc_exp = 0; exp_r = '0;
      if (mis) lat = 1;
      else if (!wr) begin
         lat = 2; exp_r = model_load(exp_mem[idx], off, nb, uns);
      end else if (nb == 4) begin
         lat = 2; we_cnt_exp = 1; we_cyc_exp = 1; exp_mem[idx] = wdata;
      end else begin
         lat = 3; we_cnt_exp = 1; we_cyc_exp = 2; exp_mem[idx] = model_store(exp_mem[idx], off, nb, wdata);
      end
      exp_q.push_back(exp_r);

      @(negedge clk);
      check("ready_idle", req_ready, 1);
      check("resp_idle", resp_valid, 0);
      check("rdata_hold", resp_rdata, last_rdata);
      check("mis_hold", resp_misaligned, last_mis);
      req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
      req_size = size; req_unsigned = uns;
      @(posedge clk);
      #1;
      req_valid = hold_valid; req_write = $urandom_range(0, 1); req_addr = $urandom;
      req_wdata = $urandom; req_size = $urandom_range(0, 3); req_unsigned = $urandom_range(0, 1);
      resp_cyc = 0; we_cnt = 0; we_cyc = 0; got_rdata = '0; got_mis = 1'b0;
      for (int k = 1; k <= 8 && resp_cyc == 0; k++) begin
         @(negedge clk);
         if (mem_write_enable) begin we_cnt++; we_cyc = k; end
         if (resp_valid) begin
            resp_cyc = k; got_rdata = resp_rdata; got_mis = resp_misaligned;
            req_valid = 1'b0;
         end
      end
      req_valid = 1'b0;
      check("latency", resp_cyc, lat);
      check("rdata", got_rdata, exp_q.pop_front());
      check("misaligned", got_mis, mis);
      check("we_count", we_cnt, we_cnt_exp);
      check("we_cycle", we_cyc, we_cyc_exp);
      check("mem_word", mem[idx], exp_mem[idx]);
      check("mem_idx_hi", mem_idx[31:6], 0);
      last_rdata = exp_r;
      last_mis   = mis;
   endtask

   initial begin
      #2;
      check("rst_ready", req_ready, 1);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_rdata", resp_rdata, 0);
      check("rst_mis", resp_misaligned, 0);
      check("rst_we", mem_write_enable, 0);
      check("rst_mem_idx", mem_idx, 0);
      check("rst_wdata", mem_write_data, 0);
      check("rst_state", dbg_state, 0);
      for (int i = 0; i < 16; i++) init_mem(i, $urandom);
      init_mem(1, 32'h8000FF0F);
      init_mem(2, 32'h00000060);
      @(negedge clk);
      tb_wr = 1'b0;
      rst_n = 1'b1;

      do_req(0, 32'd4, 32'h0, 2'b00, 0, 0);
      do_req(0, 32'd5, 32'h0, 2'b00, 0, 1);
      do_req(0, 32'd5, 32'h0, 2'b00, 1, 0);
      do_req(0, 32'd6, 32'h0, 2'b01, 0, 0);
      do_req(0, 32'd6, 32'h0, 2'b01, 1, 1);
      do_req(1, 32'd9, 32'hAB, 2'b00, 0, 0);
      check("sb_merge", mem[2], 32'h0000AB60);
      do_req(1, 32'd8, 32'h12345678, 2'b10, 0, 1);
      do_req(1, 32'd6, 32'hCAFEF00D, 2'b10, 0, 0);
      do_req(0, 32'd7, 32'h0, 2'b11, 1, 0);

      for (int n = 0; n < 80; n++)
         do_req($urandom_range(0, 1), $urandom_range(0, 63), $urandom, $urandom_range(0, 3),
                $urandom_range(0, 1), $urandom_range(0, 1));
      for (int i = 0; i < 16; i++) check("mem_final", mem[i], exp_mem[i]);

      // Reset pulsed while a byte store sits in MERGE_WR: the write must never land.
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'd13; req_wdata = ~exp_mem[3];
      req_size = 2'b00; req_unsigned = 1'b0;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(posedge clk);
      #1;
      check("merge_we", mem_write_enable, 1);
      #1 rst_n = 1'b0;
      #1;
      check("abort_we", mem_write_enable, 0);
      check("abort_ready", req_ready, 1);
      check("abort_resp", resp_valid, 0);
      check("abort_rdata", resp_rdata, 0);
      check("abort_mem_idx", mem_idx, 0);
      check("abort_wdata", mem_write_data, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("abort_no_resp", resp_valid, 0);
      end
      check("abort_mem", mem[3], exp_mem[3]);
      last_rdata = '0;
      last_mis   = 1'b0;
      do_req(0, 32'd12, 32'h0, 2'b10, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
